// File: rtl/cpu_pkg.sv
// Shared definitions for the ARM datapath: condition codes, flag bit positions
// and FlagW strobe positions.
package cpu_pkg;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int FLAGW_NZ = 1;
   localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Pure combinational evaluation of the 4-bit condition field against the
// registered NZCV flags.
module cond_check
   import cpu_pkg::*;
(
   input  logic [3:0] Cond,
   input  logic [3:0] Flags,
   output logic       CondEx
);

   logic n, z, c, v;

   assign n = Flags[FLAG_N];
   assign z = Flags[FLAG_Z];
   assign c = Flags[FLAG_C];
   assign v = Flags[FLAG_V];

   // NOTE: defaulting the output before the case keeps always_comb latch-free
   // even if a branch is later removed.
   always_comb begin
      CondEx = 1'b0;
      case (Cond)
         COND_EQ: CondEx = z;
         COND_NE: CondEx = !z;
         COND_CS: CondEx = c;
         COND_CC: CondEx = !c;
         COND_MI: CondEx = n;
         COND_PL: CondEx = !n;
         COND_VS: CondEx = v;
         COND_VC: CondEx = !v;
         COND_HI: CondEx = c & !z;
         COND_LS: CondEx = !c | z;
         COND_GE: CondEx = (n == v);
         COND_LT: CondEx = (n != v);
         COND_GT: CondEx = !z & (n == v);
         COND_LE: CondEx = z | (n != v);
         COND_AL: CondEx = 1'b1;
         COND_NV: CondEx = 1'b0;
         default: CondEx = 1'b0;
      endcase
   end

endmodule

// File: rtl/cond_unit.sv
// Conditional-execution stage: NZCV flag register, write-strobe gating and
// saturating executed/squashed instruction counters.
module cond_unit
   import cpu_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             InstrValid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SquashCount
);

   logic go;

   // Evaluated against the registered flags; ALUFlags is never bypassed.
   cond_check u_cond_check (
      .Cond   (Cond),
      .Flags  (Flags),
      .CondEx (CondEx)
   );

   assign go       = InstrValid & CondEx;
   assign PCSrc    = PCS  & go;
   assign RegWrite = RegW & go & !NoWrite;
   assign MemWrite = MemW & go;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Flags <= 4'b0000;
      end else if (go) begin
         if (FlagW[FLAGW_NZ]) Flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
         if (FlagW[FLAGW_CV]) Flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      end
   end

   // Counters stick at all-ones rather than wrapping.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ExecCount   <= '0;
         SquashCount <= '0;
      end else if (InstrValid) begin
         if (CondEx) begin
            if (!(&ExecCount)) ExecCount <= ExecCount + CNT_W'(1);
         end else begin
            if (!(&SquashCount)) SquashCount <= SquashCount + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_cond_unit.sv
// Self-checking bench for cond_unit: directed scenarios followed by random
// instruction streams compared against a behavioural flag/counter model.
module tb_cond_unit;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             InstrValid;
   logic [3:0]       Cond;
   logic [3:0]       ALUFlags;
   logic [1:0]       FlagW;
   logic             PCS, RegW, MemW, NoWrite;
   logic             PCSrc, RegWrite, MemWrite, CondEx;
   logic [3:0]       Flags;
   logic [CNT_W-1:0] ExecCount, SquashCount;

   int n_cmp = 0;
   int n_err = 0;

   logic [3:0] m_flags;
   int         m_exec;
   int         m_squash;

   cond_unit #(.CNT_W(CNT_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .InstrValid  (InstrValid),
      .Cond        (Cond),
      .ALUFlags    (ALUFlags),
      .FlagW       (FlagW),
      .PCS         (PCS),
      .RegW        (RegW),
      .MemW        (MemW),
      .NoWrite     (NoWrite),
      .PCSrc       (PCSrc),
      .RegWrite    (RegWrite),
      .MemWrite    (MemWrite),
      .CondEx      (CondEx),
      .Flags       (Flags),
      .ExecCount   (ExecCount),
      .SquashCount (SquashCount)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Conditions come in pass/fail pairs: even code tests a base predicate,
   // odd code its inverse; 1110/1111 pair as always/never.
   function automatic logic model_cond(input logic [3:0] cc, input logic [3:0] f);
      logic nn, zz, cy, vv, base;
      {nn, zz, cy, vv} = f;
      case (cc[3:1])
         3'd0: base = zz;
         3'd1: base = cy;
         3'd2: base = nn;
         3'd3: base = vv;
         3'd4: base = cy && !zz;
         3'd5: base = (nn == vv);
         3'd6: base = !zz && (nn == vv);
         default: base = 1'b1;
      endcase
      return base ^ cc[0];
   endfunction

   task automatic model_reset();
      m_flags  = 4'b0000;
      m_exec   = 0;
      m_squash = 0;
   endtask

   task automatic check_state(input string tag);
      check({tag, ".flags"},  32'(Flags),       32'(m_flags));
      check({tag, ".exec"},   32'(ExecCount),   32'(m_exec));
      check({tag, ".squash"}, 32'(SquashCount), 32'(m_squash));
   endtask

   // One instruction: drive, check same-cycle outputs, clock, check state.
   task automatic cycle(input string tag, input logic v, input logic [3:0] cc,
                        input logic [3:0] af, input logic [1:0] fw,
                        input logic pcs, input logic rw, input logic mw, input logic nw);
      logic pass, g;
      InstrValid = v; Cond = cc; ALUFlags = af; FlagW = fw;
      PCS = pcs; RegW = rw; MemW = mw; NoWrite = nw;
      #2;
      pass = model_cond(cc, m_flags);
      g    = v && pass;
      check({tag, ".condex"},   32'(CondEx),   32'(pass));
      check({tag, ".pcsrc"},    32'(PCSrc),    32'(pcs && g));
      check({tag, ".regwrite"}, 32'(RegWrite), 32'(rw && g && !nw));
      check({tag, ".memwrite"}, 32'(MemWrite), 32'(mw && g));
      @(posedge clk);
      if (v) begin
         if (g) begin
            if (fw[1]) m_flags[3:2] = af[3:2];
            if (fw[0]) m_flags[1:0] = af[1:0];
         end
         if (pass) m_exec   = (m_exec   < CMAX) ? m_exec + 1   : CMAX;
         else      m_squash = (m_squash < CMAX) ? m_squash + 1 : CMAX;
      end
      #1;
      check_state(tag);
   endtask

   task automatic do_reset(input string tag);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_state(tag);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b1;
      InstrValid = 0; Cond = 4'hE; ALUFlags = 0; FlagW = 0;
      PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
      model_reset();
      #2;

      // 1. Reset, and condition evaluation from reset flags
      rst_n = 1'b0;
      #1;
      check_state("rst");
      Cond = 4'b0000; #1; check("rst.eq", 32'(CondEx), 32'd0);
      Cond = 4'b0001; #1; check("rst.ne", 32'(CondEx), 32'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // 2. Full flag write, then EQ sees it the following cycle
      cycle("fw_all", 1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
      check("fw_all.const", 32'(Flags), 32'h4);
      cycle("eq_regw", 1, 4'h0, 4'b1011, 2'b00, 0, 1, 0, 0);

      // 3. Partial writes
      cycle("set_f", 1, 4'hE, 4'b1111, 2'b11, 0, 0, 0, 0);
      cycle("wr_cv", 1, 4'hE, 4'b0000, 2'b01, 0, 0, 0, 0);
      check("wr_cv.const", 32'(Flags), 32'hC);
      cycle("wr_nz", 1, 4'hE, 4'b0000, 2'b10, 0, 0, 0, 0);
      check("wr_nz.const", 32'(Flags), 32'h0);

      // 4. Squashed flag-setting instruction
      cycle("set_z", 1, 4'hE, 4'b0100, 2'b11, 0, 0, 0, 0);
      cycle("squash", 1, 4'h1, 4'b1011, 2'b11, 1, 1, 1, 0);
      check("squash.flags_const", 32'(Flags), 32'h4);

      // 5. Signed conditions and NoWrite
      cycle("set_nv", 1, 4'hE, 4'b1001, 2'b11, 0, 0, 0, 0);
      cycle("ge_pass", 1, 4'hA, 4'b0000, 2'b00, 0, 1, 0, 0);
      cycle("lt_fail", 1, 4'hB, 4'b0000, 2'b00, 0, 1, 0, 0);
      cycle("gt_pass", 1, 4'hC, 4'b0000, 2'b00, 0, 1, 0, 0);
      cycle("set_n", 1, 4'hE, 4'b1000, 2'b11, 0, 0, 0, 0);
      cycle("ge_fail", 1, 4'hA, 4'b0000, 2'b00, 0, 1, 0, 0);
      cycle("le_pass", 1, 4'hD, 4'b0000, 2'b00, 0, 1, 0, 0);
      cycle("nowrite", 1, 4'hE, 4'b0000, 2'b00, 0, 1, 0, 1);

      // 6. Bubble, then saturation
      cycle("bubble", 0, 4'hE, 4'b0110, 2'b11, 1, 1, 1, 0);
      do_reset("rst2");
      for (int i = 0; i < 20; i++) cycle("sat", 1, 4'hE, 4'b0000, 2'b00, 0, 0, 0, 0);
      check("sat.const", 32'(ExecCount), 32'd15);

      // Random streams with occasional asynchronous resets
      for (int blk = 0; blk < 4; blk++) begin
         do_reset("rst_rand");
         for (int i = 0; i < 60; i++) begin
            cycle("rand",
                  ($urandom_range(3, 0) != 0),
                  4'($urandom_range(15, 0)),
                  4'($urandom_range(15, 0)),
                  2'($urandom_range(3, 0)),
                  1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)),
                  1'($urandom_range(1, 0)));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
